// File: rtl/mac_result_collector.sv
// rtl/mac_result_collector.sv - round-robin drain of N_CELLS mac_cell BF16 results into a tagged output FIFO
module mac_result_collector #(
    parameter int N_CELLS    = 4,
    parameter int FIFO_DEPTH = 8,
    localparam int IDX_W     = $clog2(N_CELLS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   tile_start,
    input  logic [N_CELLS-1:0]     mac_valid_i,
    input  logic [16*N_CELLS-1:0]  mac_bf16_i,
    output logic [N_CELLS-1:0]     output_ready_o,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [15:0]            out_data,
    output logic [IDX_W-1:0]       out_idx,
    output logic                   busy,
    output logic                   tile_done
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(N_CELLS + 1);
    localparam int EW = IDX_W + 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic [EW-1:0]      mem [FIFO_DEPTH];
    logic [AW:0]        wr_ptr, rd_ptr, fifo_cnt;
    logic               full, empty, push, pop;

    logic [N_CELLS-1:0] qual_q, taken, eligible;
    logic [IDX_W-1:0]   rr_ptr, grant_idx, rr_next;
    logic               grant, start_acc;
    logic [15:0]        grant_data;
    logic [CW-1:0]      acc_cnt, pop_cnt;

    // Position k of the round-robin search, starting at the pointer and wrapping at N_CELLS.
    function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= N_CELLS) s = s - N_CELLS;
        return IDX_W'(s);
    endfunction

    assign fifo_cnt  = wr_ptr - rd_ptr;
    assign full      = (fifo_cnt == (AW+1)'(FIFO_DEPTH));
    assign empty     = (wr_ptr == rd_ptr);
    assign out_valid = !empty;
    assign {out_idx, out_data} = mem[rd_ptr[AW-1:0]];
    assign pop       = out_valid && out_ready;
    assign push      = grant;
    assign rr_next   = (grant_idx == IDX_W'(N_CELLS - 1)) ? '0 : grant_idx + 1'b1;

    // A full FIFO can still take a result when the head leaves on the same edge.
    always_comb begin
        eligible       = '0;
        grant          = 1'b0;
        grant_idx      = '0;
        output_ready_o = '0;
        if (state == S_RUN && acc_cnt < CW'(N_CELLS) && (!full || pop))
            eligible = mac_valid_i & qual_q & ~taken;
        for (int k = N_CELLS - 1; k >= 0; k--) begin
            if (eligible[rr_idx(rr_ptr, k)]) begin
                grant     = 1'b1;
                grant_idx = rr_idx(rr_ptr, k);
            end
        end
        if (grant) output_ready_o[grant_idx] = 1'b1;
        grant_data = mac_bf16_i[16*int'(grant_idx) +: 16];
    end

    always_comb begin
        state_nx  = state;
        start_acc = 1'b0;
        busy      = (state != S_IDLE);
        tile_done = (state == S_DONE);
        case (state)
            S_IDLE: begin
                if (tile_start) begin
                    start_acc = 1'b1;
                    state_nx  = S_RUN;
                end
            end
            S_RUN:   if (pop_cnt == CW'(N_CELLS)) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= {grant_idx, grant_data};
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // The bus is only trusted once mac_valid has been high for a full cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            qual_q  <= '0;
            taken   <= '0;
            rr_ptr  <= '0;
            acc_cnt <= '0;
            pop_cnt <= '0;
        end else begin
            state  <= state_nx;
            qual_q <= mac_valid_i & ~output_ready_o;
            if (start_acc) begin
                taken   <= '0;
                acc_cnt <= '0;
                pop_cnt <= '0;
            end else begin
                if (grant) begin
                    taken[grant_idx] <= 1'b1;
                    acc_cnt          <= acc_cnt + 1'b1;
                    rr_ptr           <= rr_next;
                end
                if (pop && state == S_RUN && pop_cnt < CW'(N_CELLS))
                    pop_cnt <= pop_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mac_result_collector.sv
// tb/tb_mac_result_collector.sv - randomized and directed bench for mac_result_collector
module tb_mac_result_collector;

    localparam int N = 4;

    logic            clk, rst_n, tile_start, out_ready;
    logic [N-1:0]    mac_valid;
    logic [16*N-1:0] mac_bf16;

    logic [N-1:0]    a_ordy, b_ordy;
    logic            a_ov, b_ov, a_busy, b_busy, a_td, b_td;
    logic [15:0]     a_od, b_od;
    logic [1:0]      a_oi, b_oi;

    logic            sel;
    logic [N-1:0]    m_ordy;
    logic            m_ov, m_busy, m_td;
    logic [15:0]     m_od;
    logic [1:0]      m_oi;

    mac_result_collector #(.N_CELLS(N), .FIFO_DEPTH(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .tile_start(tile_start),
        .mac_valid_i(mac_valid), .mac_bf16_i(mac_bf16), .output_ready_o(a_ordy),
        .out_valid(a_ov), .out_ready(out_ready), .out_data(a_od), .out_idx(a_oi),
        .busy(a_busy), .tile_done(a_td)
    );

    mac_result_collector #(.N_CELLS(N), .FIFO_DEPTH(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .tile_start(tile_start),
        .mac_valid_i(mac_valid), .mac_bf16_i(mac_bf16), .output_ready_o(b_ordy),
        .out_valid(b_ov), .out_ready(out_ready), .out_data(b_od), .out_idx(b_oi),
        .busy(b_busy), .tile_done(b_td)
    );

    assign m_ordy = sel ? b_ordy : a_ordy;
    assign m_ov   = sel ? b_ov   : a_ov;
    assign m_busy = sel ? b_busy : a_busy;
    assign m_td   = sel ? b_td   : a_td;
    assign m_od   = sel ? b_od   : a_od;
    assign m_oi   = sel ? b_oi   : a_oi;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // cell model: a cell shows junk on the first valid cycle, the real result afterwards,
    // and withdraws valid after the edge on which it was granted
    bit          pend [N];
    int          age  [N];
    int          arm  [N];
    logic [15:0] cdata[N];
    logic [15:0] cjunk[N];
    bit          rand_ready;

    int          grant_q[$];
    int          grant_cyc_q[$];
    logic [17:0] pop_q[$];
    int          tdone_cnt, cyc, onehot_err, elig_err;
    int          n_checks, n_pass;

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            mac_valid[i]       = pend[i];
            mac_bf16[16*i +: 16] = (pend[i] && age[i] >= 1) ? cdata[i] : cjunk[i];
        end
    endtask

    task automatic raise_now(input int i, input logic [15:0] d, input logic [15:0] j);
        pend[i] = 1; age[i] = 0; arm[i] = -1; cdata[i] = d; cjunk[i] = j;
        drive();
    endtask

    task automatic cycle();
        logic [N-1:0] g;
        @(negedge clk);
        cyc++;
        g = m_ordy;
        if ($countones(g) > 1) onehot_err++;
        for (int i = 0; i < N; i++) begin
            if (g[i]) begin
                if (!pend[i] || age[i] < 1) elig_err++;
                grant_q.push_back(i);
                grant_cyc_q.push_back(cyc);
            end
        end
        if (m_ov && out_ready) pop_q.push_back({m_oi, m_od});
        if (m_td) tdone_cnt++;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (g[i]) pend[i] = 0;
        for (int i = 0; i < N; i++) if (pend[i]) age[i]++;
        for (int i = 0; i < N; i++) begin
            if (arm[i] == 0) begin
                pend[i] = 1; age[i] = 0; arm[i] = -1;
            end else if (arm[i] > 0) begin
                arm[i]--;
            end
        end
        if (rand_ready) out_ready = ($urandom_range(9) < 7);
        drive();
    endtask

    task automatic clear_sb();
        grant_q.delete();
        grant_cyc_q.delete();
        pop_q.delete();
        tdone_cnt = 0;
    endtask

    task automatic do_reset();
        rst_n = 0; tile_start = 0; out_ready = 0; rand_ready = 0;
        for (int i = 0; i < N; i++) begin
            pend[i] = 0; age[i] = 0; arm[i] = -1; cdata[i] = '0; cjunk[i] = '0;
        end
        drive();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        clear_sb();
    endtask

    task automatic pulse_start();
        tile_start = 1;
        cycle();
        tile_start = 0;
    endtask

    task automatic wait_done(input int limit, output bit timed_out);
        for (int k = 0; k < limit && tdone_cnt == 0; k++) cycle();
        timed_out = (tdone_cnt == 0);
        repeat (3) cycle();
    endtask

    task automatic test_reset();
        sel = 0;
        do_reset();
        n_checks++; if (m_ov !== 1'b0)   $display("FAIL rst_out_valid got %b want 0", m_ov);   else n_pass++;
        n_checks++; if (m_ordy !== '0)   $display("FAIL rst_output_ready got %b want 0", m_ordy); else n_pass++;
        n_checks++; if (m_busy !== 1'b0) $display("FAIL rst_busy got %b want 0", m_busy);     else n_pass++;
        n_checks++; if (m_td !== 1'b0)   $display("FAIL rst_tile_done got %b want 0", m_td);  else n_pass++;
        n_checks++; if ({m_oi, m_od} !== 18'h0) $display("FAIL rst_out_data got %h want 0", {m_oi, m_od}); else n_pass++;
        pulse_start();
        for (int i = 0; i < N; i++) raise_now(i, 16'($urandom), 16'($urandom));
        for (int k = 0; k < 12 && grant_q.size() < 3; k++) cycle();
        n_checks++; if (grant_q.size() !== 3) $display("FAIL rst_prefill grants got %0d want 3", grant_q.size()); else n_pass++;
        n_checks++; if (m_ov !== 1'b1) $display("FAIL rst_prefill out_valid got %b want 1", m_ov); else n_pass++;
        n_checks++; if (m_ordy !== 4'b1000) $display("FAIL rst_prefill output_ready got %b want 1000", m_ordy); else n_pass++;
        #1 rst_n = 0;
        #1;
        n_checks++; if (m_ov !== 1'b0)   $display("FAIL rst_mid out_valid got %b want 0", m_ov);       else n_pass++;
        n_checks++; if (m_ordy !== '0)   $display("FAIL rst_mid output_ready got %b want 0", m_ordy);  else n_pass++;
        n_checks++; if (m_busy !== 1'b0) $display("FAIL rst_mid busy got %b want 0", m_busy);          else n_pass++;
    endtask

    task automatic test_single_tile();
        logic [15:0] d[N];
        logic [17:0] exp;
        int          raise_cyc;
        bit          to;
        d = '{16'h3F80, 16'h4000, 16'h4040, 16'h4080};
        sel = 0;
        do_reset();
        out_ready = 1;
        pulse_start();
        n_checks++; if (m_busy !== 1'b1) $display("FAIL t2_busy got %b want 1", m_busy); else n_pass++;
        for (int i = 0; i < N; i++) raise_now(i, d[i], ~d[i]);
        raise_cyc = cyc + 1;
        wait_done(40, to);
        n_checks++; if (to) $display("FAIL t2_timeout tile_done not seen"); else n_pass++;
        n_checks++; if (grant_q.size() !== N) $display("FAIL t2_grants got %0d want %0d", grant_q.size(), N); else n_pass++;
        for (int k = 0; k < N && k < grant_q.size(); k++) begin
            n_checks++; if (grant_q[k] !== k) $display("FAIL t2_grant_order[%0d] got %0d want %0d", k, grant_q[k], k); else n_pass++;
            n_checks++; if (grant_cyc_q[k] !== raise_cyc + 1 + k) $display("FAIL t2_grant_cycle[%0d] got %0d want %0d", k, grant_cyc_q[k], raise_cyc + 1 + k); else n_pass++;
        end
        n_checks++; if (pop_q.size() !== N) $display("FAIL t2_pops got %0d want %0d", pop_q.size(), N); else n_pass++;
        for (int k = 0; k < N && k < pop_q.size(); k++) begin
            exp = {2'(k), d[k]};
            n_checks++; if (pop_q[k] !== exp) $display("FAIL t2_pop[%0d] got %h want %h", k, pop_q[k], exp); else n_pass++;
        end
        n_checks++; if (tdone_cnt !== 1) $display("FAIL t2_tile_done_count got %0d want 1", tdone_cnt); else n_pass++;
        n_checks++; if (m_busy !== 1'b0) $display("FAIL t2_busy_after got %b want 0", m_busy); else n_pass++;
    endtask

    task automatic test_stale_data();
        bit          to, found;
        logic [15:0] got;
        sel = 0;
        do_reset();
        out_ready = 1;
        pulse_start();
        for (int i = 0; i < N; i++) begin
            if (i == 2) raise_now(i, 16'h4120, 16'hDEAD);
            else        raise_now(i, 16'($urandom), 16'($urandom));
        end
        wait_done(40, to);
        found = 0; got = '0;
        foreach (pop_q[k]) if (pop_q[k][17:16] == 2'd2) begin found = 1; got = pop_q[k][15:0]; end
        n_checks++; if (to) $display("FAIL t3_timeout tile_done not seen"); else n_pass++;
        n_checks++; if (!found || got !== 16'h4120) $display("FAIL t3_stale_data got %h (found %0d) want 4120", got, found); else n_pass++;
    endtask

    task automatic test_backpressure();
        bit          to;
        logic [17:0] exp;
        sel = 1;
        do_reset();
        out_ready = 0;
        pulse_start();
        for (int i = 0; i < N; i++) raise_now(i, 16'($urandom), 16'($urandom));
        repeat (10) cycle();
        n_checks++; if (grant_q.size() !== 2) $display("FAIL t4_stalled_grants got %0d want 2", grant_q.size()); else n_pass++;
        n_checks++; if (m_ordy !== '0) $display("FAIL t4_stalled_ready got %b want 0", m_ordy); else n_pass++;
        n_checks++; if (m_ov !== 1'b1) $display("FAIL t4_stalled_valid got %b want 1", m_ov); else n_pass++;
        out_ready = 1;
        wait_done(40, to);
        n_checks++; if (to) $display("FAIL t4_timeout tile_done not seen"); else n_pass++;
        n_checks++; if (grant_q.size() !== N) $display("FAIL t4_grants got %0d want %0d", grant_q.size(), N); else n_pass++;
        n_checks++; if (pop_q.size() !== N) $display("FAIL t4_pops got %0d want %0d", pop_q.size(), N); else n_pass++;
        for (int k = 0; k < N && k < pop_q.size(); k++) begin
            exp = {2'(k), cdata[k]};
            n_checks++; if (pop_q[k] !== exp) $display("FAIL t4_pop[%0d] got %h want %h", k, pop_q[k], exp); else n_pass++;
        end
    endtask

    task automatic test_round_robin();
        bit to;
        int exp_order[N];
        exp_order = '{1, 3, 0, 2};
        sel = 0;
        do_reset();
        out_ready = 1;
        pulse_start();
        raise_now(1, 16'($urandom), 16'($urandom));
        for (int k = 0; k < 10 && grant_q.size() < 1; k++) cycle();
        raise_now(0, 16'($urandom), 16'($urandom));
        raise_now(3, 16'($urandom), 16'($urandom));
        for (int k = 0; k < 10 && grant_q.size() < 3; k++) cycle();
        raise_now(2, 16'($urandom), 16'($urandom));
        wait_done(40, to);
        n_checks++; if (to) $display("FAIL t5_timeout tile_done not seen"); else n_pass++;
        n_checks++; if (grant_q.size() !== N) $display("FAIL t5_grants got %0d want %0d", grant_q.size(), N); else n_pass++;
        for (int k = 0; k < N && k < grant_q.size(); k++) begin
            n_checks++; if (grant_q[k] !== exp_order[k]) $display("FAIL t5_rr_order[%0d] got %0d want %0d", k, grant_q[k], exp_order[k]); else n_pass++;
        end
    endtask

    task automatic test_ignore_dup();
        bit to;
        sel = 0;
        do_reset();
        out_ready = 1;
        pulse_start();
        raise_now(0, 16'($urandom), 16'($urandom));
        for (int k = 0; k < 10 && grant_q.size() < 1; k++) cycle();
        pulse_start();
        raise_now(0, 16'($urandom), 16'($urandom));
        repeat (5) cycle();
        n_checks++; if (grant_q.size() !== 1) $display("FAIL t6_dup_grants got %0d want 1", grant_q.size()); else n_pass++;
        n_checks++; if (m_busy !== 1'b1) $display("FAIL t6_busy got %b want 1", m_busy); else n_pass++;
        pend[0] = 0;
        drive();
        for (int i = 1; i < N; i++) raise_now(i, 16'($urandom), 16'($urandom));
        wait_done(40, to);
        n_checks++; if (to) $display("FAIL t6_timeout tile_done not seen"); else n_pass++;
        n_checks++; if (grant_q.size() !== N) $display("FAIL t6_grants got %0d want %0d", grant_q.size(), N); else n_pass++;
        n_checks++; if (tdone_cnt !== 1) $display("FAIL t6_tile_done_count got %0d want 1", tdone_cnt); else n_pass++;
    endtask

    task automatic test_random();
        bit          to;
        logic [N-1:0] seen;
        int          idx;
        for (int t = 0; t < 6; t++) begin
            if (t == 0) begin sel = 0; do_reset(); end
            if (t == 3) begin sel = 1; do_reset(); end
            clear_sb();
            rand_ready = 1;
            pulse_start();
            for (int i = 0; i < N; i++) begin
                cdata[i] = 16'($urandom);
                cjunk[i] = ~cdata[i];
                arm[i]   = $urandom_range(6);
            end
            wait_done(300, to);
            rand_ready = 0;
            out_ready  = 1;
            n_checks++; if (to) $display("FAIL rnd%0d_timeout tile_done not seen", t); else n_pass++;
            n_checks++; if (pop_q.size() !== N) $display("FAIL rnd%0d_pops got %0d want %0d", t, pop_q.size(), N); else n_pass++;
            n_checks++; if (tdone_cnt !== 1) $display("FAIL rnd%0d_tile_done_count got %0d want 1", t, tdone_cnt); else n_pass++;
            seen = '0;
            for (int k = 0; k < pop_q.size(); k++) begin
                idx = int'(pop_q[k][17:16]);
                seen[idx] = 1'b1;
                n_checks++; if (pop_q[k][15:0] !== cdata[idx]) $display("FAIL rnd%0d_data cell %0d got %h want %h", t, idx, pop_q[k][15:0], cdata[idx]); else n_pass++;
                n_checks++; if (k >= grant_q.size() || grant_q[k] !== idx) $display("FAIL rnd%0d_order[%0d] popped cell %0d not grant order", t, k, idx); else n_pass++;
            end
            n_checks++; if (seen !== 4'hF) $display("FAIL rnd%0d_coverage got %b want 1111", t, seen); else n_pass++;
        end
        n_checks++; if (onehot_err !== 0) $display("FAIL onehot_grant got %0d violations want 0", onehot_err); else n_pass++;
        n_checks++; if (elig_err !== 0) $display("FAIL grant_eligibility got %0d violations want 0", elig_err); else n_pass++;
    endtask

    initial begin
        n_checks = 0; n_pass = 0; cyc = 0; onehot_err = 0; elig_err = 0;
        sel = 0; rand_ready = 0; rst_n = 0; tile_start = 0; out_ready = 0;
        mac_valid = '0; mac_bf16 = '0;
        test_reset();
        test_single_tile();
        test_stale_data();
        test_backpressure();
        test_round_robin();
        test_ignore_dup();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
